cpu_mem_responder: RTL and testbench
====================================

Name: cpu_mem_responder

Overview:
Memory-side responder for CPU_Top's exported memory ports. It serves the read-only instruction port (imem_*) and the two-port data port (dmem_*) from on-chip arrays with 1-cycle registered read latency. A valid/ready program loader fills both arrays before execution; a small FSM then issues a one-cycle start pulse to the CPU. Sits beside CPU_Top in the SoC/bench top.

Parameters:
INST_ADDR_WIDTH, 8, imem address width
INST_DATA_WIDTH, 32, instruction word width
MEM_ADDR_WIDTH, 8, dmem address width
MEM_DATA_WIDTH, 32, dmem word width
IMEM_DEPTH, 256, implemented imem words (≤ 2^INST_ADDR_WIDTH)
DMEM_DEPTH, 256, implemented dmem words (≤ 2^MEM_ADDR_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
imem_en  in  1  instruction read enable
imem_addr  in  INST_ADDR_WIDTH  instruction address
imem_data  out  INST_DATA_WIDTH  instruction read data
dmem_waddr  in  MEM_ADDR_WIDTH  data write address
dmem_wdata  in  MEM_DATA_WIDTH  data write word
dmem_wen  in  1  data write enable
dmem_raddr  in  MEM_ADDR_WIDTH  data read address
dmem_rdata  out  MEM_DATA_WIDTH  data read word
dmem_ren  in  1  data read enable
ld_valid  in  1  loader beat valid
ld_ready  out  1  loader beat ready
ld_sel  in  1  0 = imem target, 1 = dmem target
ld_addr  in  max(INST_ADDR_WIDTH,MEM_ADDR_WIDTH)  loader word address (low bits used per target)
ld_data  in  max(INST_DATA_WIDTH,MEM_DATA_WIDTH)  loader word (low bits used per target)
ld_last  in  1  final beat of program image
reload  in  1  pulse in RUN: return to IDLE for a new image
start  out  1  one-cycle CPU start pulse
load_cnt  out  16  accepted loader beats
err_oob  out  1  sticky out-of-range access flag

Behaviour:
- Reset (rst=0, async): state=IDLE; imem_data=0, dmem_rdata=0, start=0, ld_ready=0, load_cnt=0, err_oob=0. Array contents are not reset and survive reset.
- ld_ready is registered: 1 in IDLE/LOAD, 0 in START/RUN. It first rises on the first clk edge after rst deasserts.
- A beat is accepted on a clk edge when ld_valid && ld_ready; it writes ld_data into the array selected by ld_sel at ld_addr. load_cnt increments and saturates at 0xFFFF.
- FSM transitions:
  - IDLE: on an accepted beat → LOAD, or → START if ld_last.
  - LOAD: on an accepted beat with ld_last → START.
  - START: start=1 for exactly this one cycle → RUN.
  - RUN: on reload=1 → IDLE and load_cnt cleared. reload is ignored in other states.
- START timing: start is high in the cycle immediately after the edge that accepted the last beat.
- CPU write gating: dmem_wen is honoured only in START/RUN and ignored in IDLE/LOAD. Loader writes occur only in IDLE/LOAD, so CPU and loader writes never collide.
- Reads are serviced in every state:
  - imem: imem_data <= imem[imem_addr] on an edge with imem_en=1, else holds.
  - dmem: dmem_rdata <= dmem[dmem_raddr] on an edge with dmem_ren=1, else holds.
- Out of range (addr ≥ IMEM_DEPTH or DMEM_DEPTH), from CPU or loader:
  - write dropped;
  - read returns 0;
  - err_oob set to 1 and cleared only by reset.
  - The loader beat is still accepted and counted.
- Same-cycle dmem write and read to the same address: see Optional Feature.
- Reset mid-load: FSM → IDLE, load_cnt=0, no start pulse. Already-written words remain.

Optional Feature:
MEM_RESP_WRITE_FIRST_EN
- Defined: a same-address simultaneous dmem write+read returns the new wdata on dmem_rdata next cycle (write-first bypass). The same rule applies to a same-address imem loader write and imem read.
- Undefined: read-first; the old array word is returned and the new word is visible from the following read.

Test Plan:
1. Reset, then 4 imem beats (addr 0..3, data 0x11,0x22,0x33,0x44, ld_last on beat 4, ld_valid held) → ld_ready=1 throughout; start=1 for exactly one cycle right after beat 4; load_cnt=4; ld_ready=0 afterwards.
2. RUN, imem_en=1 addr 2 → imem_data=0x33 next cycle; then imem_en=0 addr 3 → imem_data stays 0x33.
3. RUN, dmem_wen=1 waddr=5 wdata=0xDEADBEEF with dmem_ren=1 raddr=5 (prior content 0x0) → next cycle dmem_rdata=0xDEADBEEF with macro, 0x0 without; a subsequent read returns 0xDEADBEEF in both builds.
4. DMEM_DEPTH=128: CPU write addr 200 data 0x55, then read addr 200 → dmem_rdata=0, err_oob=1; err_oob survives reload and clears only on rst=0.
5. RUN, pulse reload → IDLE, ld_ready=1, load_cnt=0; CPU dmem_wen addr 7 data 0x99 in IDLE → a later read of addr 7 returns the prior value, not 0x99.
6. Assert rst=0 asynchronously after 2 of 4 beats → outputs zero immediately, start never pulses; after release, reload only beats 2..3 with ld_last → imem addr 0..1 still read 0x11/0x22.

Source files
------------

// File: rtl/cpu_mem_responder_if.sv
// Bundle of CPU memory ports and program-loader signals between CPU_Top/bench and the responder.
// master = CPU + loader side, slave = memory responder.
interface cpu_mem_responder_if #(
  parameter int unsigned INST_ADDR_WIDTH = 8,
  parameter int unsigned INST_DATA_WIDTH = 32,
  parameter int unsigned MEM_ADDR_WIDTH  = 8,
  parameter int unsigned MEM_DATA_WIDTH  = 32
);
  localparam int unsigned LD_ADDR_WIDTH =
    (INST_ADDR_WIDTH > MEM_ADDR_WIDTH) ? INST_ADDR_WIDTH : MEM_ADDR_WIDTH;
  localparam int unsigned LD_DATA_WIDTH =
    (INST_DATA_WIDTH > MEM_DATA_WIDTH) ? INST_DATA_WIDTH : MEM_DATA_WIDTH;

  logic                       imem_en;
  logic [INST_ADDR_WIDTH-1:0] imem_addr;
  logic [INST_DATA_WIDTH-1:0] imem_data;
  logic [MEM_ADDR_WIDTH-1:0]  dmem_waddr;
  logic [MEM_DATA_WIDTH-1:0]  dmem_wdata;
  logic                       dmem_wen;
  logic [MEM_ADDR_WIDTH-1:0]  dmem_raddr;
  logic [MEM_DATA_WIDTH-1:0]  dmem_rdata;
  logic                       dmem_ren;
  logic                       ld_valid;
  logic                       ld_ready;
  logic                       ld_sel;
  logic [LD_ADDR_WIDTH-1:0]   ld_addr;
  logic [LD_DATA_WIDTH-1:0]   ld_data;
  logic                       ld_last;
  logic                       reload;
  logic                       start;
  logic [15:0]                load_cnt;
  logic                       err_oob;

  modport master (
    output imem_en, imem_addr, dmem_waddr, dmem_wdata, dmem_wen, dmem_raddr, dmem_ren,
           ld_valid, ld_sel, ld_addr, ld_data, ld_last, reload,
    input  imem_data, dmem_rdata, ld_ready, start, load_cnt, err_oob
  );

  modport slave (
    input  imem_en, imem_addr, dmem_waddr, dmem_wdata, dmem_wen, dmem_raddr, dmem_ren,
           ld_valid, ld_sel, ld_addr, ld_data, ld_last, reload,
    output imem_data, dmem_rdata, ld_ready, start, load_cnt, err_oob
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// Instruction/data memory responder with valid/ready program loader and CPU start pulse.
// Optional macro MEM_RESP_WRITE_FIRST_EN: write-first bypass for same-address write+read.
module cpu_mem_responder #(
  parameter int unsigned INST_ADDR_WIDTH = 8,
  parameter int unsigned INST_DATA_WIDTH = 32,
  parameter int unsigned MEM_ADDR_WIDTH  = 8,
  parameter int unsigned MEM_DATA_WIDTH  = 32,
  parameter int unsigned IMEM_DEPTH      = 256,
  parameter int unsigned DMEM_DEPTH      = 256
) (
  input logic                 clk,
  input logic                 rst,
  cpu_mem_responder_if.slave  bus
);
  localparam int unsigned IMEM_IDX_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int unsigned DMEM_IDX_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  // One extra bit so a depth of 2^width is representable in the range compare.
  localparam logic [INST_ADDR_WIDTH:0] IMEM_LIMIT = (INST_ADDR_WIDTH + 1)'(IMEM_DEPTH);
  localparam logic [MEM_ADDR_WIDTH:0]  DMEM_LIMIT = (MEM_ADDR_WIDTH + 1)'(DMEM_DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StStart, StRun} state_e;

  state_e                     state_q, state_d;
  logic                       ld_ready_q;
  logic [15:0]                load_cnt_q, load_cnt_d;
  logic                       err_oob_q, err_oob_d;
  logic [INST_DATA_WIDTH-1:0] imem_data_q, imem_data_d;
  logic [MEM_DATA_WIDTH-1:0]  dmem_rdata_q, dmem_rdata_d;

  logic [INST_DATA_WIDTH-1:0] imem [IMEM_DEPTH];
  logic [MEM_DATA_WIDTH-1:0]  dmem [DMEM_DEPTH];

  logic                       loading;
  logic                       ld_accept;
  logic [INST_ADDR_WIDTH-1:0] imem_waddr;
  logic [INST_DATA_WIDTH-1:0] imem_wdata;
  logic                       imem_wreq, imem_we, imem_wa_ok, imem_ra_ok;
  logic [MEM_ADDR_WIDTH-1:0]  dmem_waddr;
  logic [MEM_DATA_WIDTH-1:0]  dmem_wdata;
  logic                       dmem_wreq, dmem_we, dmem_wa_ok, dmem_ra_ok;

  assign loading   = (state_q == StIdle) || (state_q == StLoad);
  assign ld_accept = bus.ld_valid && ld_ready_q;

  // imem is written only by the loader.
  assign imem_waddr = bus.ld_addr[INST_ADDR_WIDTH-1:0];
  assign imem_wdata = bus.ld_data[INST_DATA_WIDTH-1:0];
  assign imem_wreq  = ld_accept && !bus.ld_sel;
  assign imem_wa_ok = {1'b0, imem_waddr} < IMEM_LIMIT;
  assign imem_ra_ok = {1'b0, bus.imem_addr} < IMEM_LIMIT;
  assign imem_we    = imem_wreq && imem_wa_ok;

  // Single dmem write port: loader owns it in IDLE/LOAD, CPU owns it in START/RUN.
  assign dmem_waddr = loading ? bus.ld_addr[MEM_ADDR_WIDTH-1:0] : bus.dmem_waddr;
  assign dmem_wdata = loading ? bus.ld_data[MEM_DATA_WIDTH-1:0] : bus.dmem_wdata;
  assign dmem_wreq  = loading ? (ld_accept && bus.ld_sel) : bus.dmem_wen;
  assign dmem_wa_ok = {1'b0, dmem_waddr} < DMEM_LIMIT;
  assign dmem_ra_ok = {1'b0, bus.dmem_raddr} < DMEM_LIMIT;
  assign dmem_we    = dmem_wreq && dmem_wa_ok;

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    if (ld_accept && (load_cnt_q != 16'hFFFF)) begin
      load_cnt_d = load_cnt_q + 16'd1;
    end
    case (state_q)
      StIdle: begin
        if (ld_accept) state_d = bus.ld_last ? StStart : StLoad;
      end
      StLoad: begin
        if (ld_accept && bus.ld_last) state_d = StStart;
      end
      StStart: state_d = StRun;
      StRun: begin
        if (bus.reload) begin
          state_d    = StIdle;
          load_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    err_oob_d = err_oob_q
              | (imem_wreq && !imem_wa_ok)
              | (dmem_wreq && !dmem_wa_ok)
              | (bus.imem_en && !imem_ra_ok)
              | (bus.dmem_ren && !dmem_ra_ok);
  end

  always_comb begin
    imem_data_d = imem_data_q;
    if (bus.imem_en) begin
      if (!imem_ra_ok) begin
        imem_data_d = '0;
`ifdef MEM_RESP_WRITE_FIRST_EN
      end else if (imem_we && (imem_waddr == bus.imem_addr)) begin
        imem_data_d = imem_wdata;
`endif
      end else begin
        imem_data_d = imem[bus.imem_addr[IMEM_IDX_W-1:0]];
      end
    end
  end

  always_comb begin
    dmem_rdata_d = dmem_rdata_q;
    if (bus.dmem_ren) begin
      if (!dmem_ra_ok) begin
        dmem_rdata_d = '0;
`ifdef MEM_RESP_WRITE_FIRST_EN
      end else if (dmem_we && (dmem_waddr == bus.dmem_raddr)) begin
        dmem_rdata_d = dmem_wdata;
`endif
      end else begin
        dmem_rdata_d = dmem[bus.dmem_raddr[DMEM_IDX_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      ld_ready_q   <= 1'b0;
      load_cnt_q   <= '0;
      err_oob_q    <= 1'b0;
      imem_data_q  <= '0;
      dmem_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      ld_ready_q   <= (state_d == StIdle) || (state_d == StLoad);
      load_cnt_q   <= load_cnt_d;
      err_oob_q    <= err_oob_d;
      imem_data_q  <= imem_data_d;
      dmem_rdata_q <= dmem_rdata_d;
    end
  end

  // Array contents are deliberately not reset so an image survives a reset.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr[IMEM_IDX_W-1:0]] <= imem_wdata;
    if (dmem_we) dmem[dmem_waddr[DMEM_IDX_W-1:0]] <= dmem_wdata;
  end

  assign bus.ld_ready   = ld_ready_q;
  assign bus.start      = (state_q == StStart);
  assign bus.load_cnt   = load_cnt_q;
  assign bus.err_oob    = err_oob_q;
  assign bus.imem_data  = imem_data_q;
  assign bus.dmem_rdata = dmem_rdata_q;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder (DMEM_DEPTH=128); expectations follow
// MEM_RESP_WRITE_FIRST_EN when defined.
module tb_cpu_mem_responder;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  cpu_mem_responder_if #(
    .INST_ADDR_WIDTH (8),
    .INST_DATA_WIDTH (32),
    .MEM_ADDR_WIDTH  (8),
    .MEM_DATA_WIDTH  (32)
  ) bus ();

  cpu_mem_responder #(
    .INST_ADDR_WIDTH (8),
    .INST_DATA_WIDTH (32),
    .MEM_ADDR_WIDTH  (8),
    .MEM_DATA_WIDTH  (32),
    .IMEM_DEPTH      (256),
    .DMEM_DEPTH      (128)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic sel, input logic [7:0] addr, input logic [31:0] data,
                      input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_sel   = sel;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    bus.ld_last  = last;
  endtask

  initial begin
    logic [31:0] exp_wf;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.imem_en = 1'b0; bus.imem_addr = '0;
    bus.dmem_waddr = '0; bus.dmem_wdata = '0; bus.dmem_wen = 1'b0;
    bus.dmem_raddr = '0; bus.dmem_ren = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_sel = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.ld_last = 1'b0; bus.reload = 1'b0;

    // Reset values
    #1 rst = 1'b0;
    #2;
    check("rst_imem_data", bus.imem_data, 32'h0);
    check("rst_dmem_rdata", bus.dmem_rdata, 32'h0);
    check("rst_start", {31'b0, bus.start}, 32'h0);
    check("rst_ld_ready", {31'b0, bus.ld_ready}, 32'h0);
    check("rst_load_cnt", {16'b0, bus.load_cnt}, 32'h0);
    check("rst_err_oob", {31'b0, bus.err_oob}, 32'h0);
    step();
    check("ld_ready_in_rst", {31'b0, bus.ld_ready}, 32'h0);
    rst = 1'b1;
    step();
    check("ld_ready_rise", {31'b0, bus.ld_ready}, 32'h1);

    // Test 1: four imem beats
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, 8'(i), 32'((i + 1) * 32'h11), i == 3);
      check("t1_ld_ready", {31'b0, bus.ld_ready}, 32'h1);
      check("t1_no_start", {31'b0, bus.start}, 32'h0);
      step();
    end
    check("t1_start", {31'b0, bus.start}, 32'h1);
    check("t1_ready_low", {31'b0, bus.ld_ready}, 32'h0);
    check("t1_load_cnt", {16'b0, bus.load_cnt}, 32'd4);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    step();
    check("t1_start_one_cycle", {31'b0, bus.start}, 32'h0);
    check("t1_ready_run", {31'b0, bus.ld_ready}, 32'h0);

    // Test 2: imem read and hold
    bus.imem_en = 1'b1; bus.imem_addr = 8'd2;
    step();
    check("t2_imem_rd", bus.imem_data, 32'h33);
    bus.imem_en = 1'b0; bus.imem_addr = 8'd3;
    step();
    check("t2_imem_hold", bus.imem_data, 32'h33);

    // Test 3: same-address write+read
    bus.dmem_wen = 1'b1; bus.dmem_waddr = 8'd5; bus.dmem_wdata = 32'h0;
    step();
    bus.dmem_wdata = 32'hDEADBEEF;
    bus.dmem_ren = 1'b1; bus.dmem_raddr = 8'd5;
    step();
`ifdef MEM_RESP_WRITE_FIRST_EN
    exp_wf = 32'hDEADBEEF;
`else
    exp_wf = 32'h0;
`endif
    check("t3_collide_rd", bus.dmem_rdata, exp_wf);
    bus.dmem_wen = 1'b0;
    step();
    check("t3_followup_rd", bus.dmem_rdata, 32'hDEADBEEF);

    // Test 4: out-of-range CPU write/read
    bus.dmem_ren = 1'b0;
    check("t4_err_clear", {31'b0, bus.err_oob}, 32'h0);
    bus.dmem_wen = 1'b1; bus.dmem_waddr = 8'd200; bus.dmem_wdata = 32'h55;
    step();
    check("t4_err_on_wr", {31'b0, bus.err_oob}, 32'h1);
    check("t4_rdata_hold", bus.dmem_rdata, 32'hDEADBEEF);
    bus.dmem_wen = 1'b0;
    bus.dmem_ren = 1'b1; bus.dmem_raddr = 8'd200;
    step();
    check("t4_oob_rd_zero", bus.dmem_rdata, 32'h0);
    check("t4_err_sticky", {31'b0, bus.err_oob}, 32'h1);

    // Test 5: reload, then gated CPU write in IDLE
    bus.dmem_ren = 1'b0;
    bus.dmem_wen = 1'b1; bus.dmem_waddr = 8'd7; bus.dmem_wdata = 32'h1234;
    step();
    bus.dmem_wen = 1'b0;
    bus.reload = 1'b1;
    step();
    bus.reload = 1'b0;
    check("t5_ready_idle", {31'b0, bus.ld_ready}, 32'h1);
    check("t5_cnt_clear", {16'b0, bus.load_cnt}, 32'h0);
    check("t5_err_survives", {31'b0, bus.err_oob}, 32'h1);
    check("t5_no_start", {31'b0, bus.start}, 32'h0);
    bus.dmem_wen = 1'b1; bus.dmem_waddr = 8'd7; bus.dmem_wdata = 32'h99;
    step();
    bus.dmem_wen = 1'b0;
    bus.dmem_ren = 1'b1; bus.dmem_raddr = 8'd7;
    step();
    check("t5_wr_gated", bus.dmem_rdata, 32'h1234);
    bus.dmem_ren = 1'b0;

    // Test 6: reset mid-load
    beat(1'b0, 8'd0, 32'hA1, 1'b0);
    step();
    beat(1'b0, 8'd1, 32'hA2, 1'b0);
    step();
    check("t6_cnt_two", {16'b0, bus.load_cnt}, 32'd2);
    bus.ld_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t6_async_ready", {31'b0, bus.ld_ready}, 32'h0);
    check("t6_async_cnt", {16'b0, bus.load_cnt}, 32'h0);
    check("t6_async_err", {31'b0, bus.err_oob}, 32'h0);
    check("t6_async_imem", bus.imem_data, 32'h0);
    check("t6_async_dmem", bus.dmem_rdata, 32'h0);
    check("t6_async_start", {31'b0, bus.start}, 32'h0);
    step();
    check("t6_rst_no_start", {31'b0, bus.start}, 32'h0);
    rst = 1'b1;
    step();
    check("t6_ready_again", {31'b0, bus.ld_ready}, 32'h1);
    check("t6_cnt_zero", {16'b0, bus.load_cnt}, 32'h0);
    beat(1'b0, 8'd2, 32'hA3, 1'b0);
    bus.imem_en = 1'b1; bus.imem_addr = 8'd2;
    step();
`ifdef MEM_RESP_WRITE_FIRST_EN
    exp_wf = 32'hA3;
`else
    exp_wf = 32'h33;
`endif
    check("t6_imem_collide", bus.imem_data, exp_wf);
    bus.imem_en = 1'b0;
    beat(1'b1, 8'd9, 32'hCAFE, 1'b0);
    step();
    check("t6_err_still_clear", {31'b0, bus.err_oob}, 32'h0);
    beat(1'b1, 8'd130, 32'h77, 1'b0);
    step();
    check("t6_ld_oob_err", {31'b0, bus.err_oob}, 32'h1);
    check("t6_ld_oob_counted", {16'b0, bus.load_cnt}, 32'd3);
    beat(1'b0, 8'd3, 32'hA4, 1'b1);
    step();
    check("t6_start", {31'b0, bus.start}, 32'h1);
    check("t6_cnt_four", {16'b0, bus.load_cnt}, 32'd4);
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    bus.imem_en = 1'b1; bus.imem_addr = 8'd0;
    step();
    check("t6_imem0_kept", bus.imem_data, 32'hA1);
    bus.imem_addr = 8'd1;
    step();
    check("t6_imem1_kept", bus.imem_data, 32'hA2);
    bus.imem_addr = 8'd3;
    bus.dmem_ren = 1'b1; bus.dmem_raddr = 8'd9;
    step();
    check("t6_imem3_new", bus.imem_data, 32'hA4);
    check("t6_dmem_loaded", bus.dmem_rdata, 32'hCAFE);
    bus.imem_en = 1'b0; bus.dmem_ren = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
